// File: rtl/shift_xfer_ctrl_if.sv
// Word-level handshakes of the serial transfer engine: load side (in_*/din)
// and result side (dout*). The controller uses the slave modport.
interface shift_xfer_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport slave (
    input  in_valid, din, dout_ready,
    output in_ready, dout, dout_valid
  );

  modport master (
    output in_valid, din, dout_ready,
    input  in_ready, dout, dout_valid
  );
endinterface

// File: rtl/shift_xfer_ctrl.sv
// Full-duplex serial transfer engine: loads a word, shifts it out MSB-first on SO
// while capturing SI, then holds the captured word until the consumer takes it.
module shift_xfer_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   abort,
  input  logic                   SI,
  output logic                   SO,
  output logic                   shift_tick,
  output logic                   busy,
  output logic [$clog2(WIDTH):0] bit_cnt,
  shift_xfer_ctrl_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               dout_valid_q, dout_valid_d;
  logic               tick;

  assign tick = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    dout_d    = dout_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the load.
        if (bus.in_valid) begin
          sreg_d    = bus.din;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = IDLE;
        end else if (tick) begin
          sreg_d    = {sreg_q[WIDTH-2:0], SI};
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            dout_d  = {sreg_q[WIDTH-2:0], SI};
            state_d = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = IDLE;
        end else if (bus.dout_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d   = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    dout_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      dout_q       <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign SO             = sreg_q[WIDTH-1];
  assign shift_tick     = tick;
  assign busy           = busy_q;
  assign bit_cnt        = bit_cnt_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Bench for shift_xfer_ctrl: two instances (DIV=1 and DIV=3) share the control
// stimulus; a transfer-level reference model predicts every output each cycle.
module tb_shift_xfer_ctrl;
  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, abort = 1'b0, in_valid = 1'b0, dout_ready = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0]   si = '0;
  logic [1:0]   so_o, tick_o, busy_o, inr_o, dv_o;
  logic [CW-1:0] bc1, bc3;
  logic [CW-1:0] bc_o [2];
  logic [W-1:0]  dout_o [2];

  shift_xfer_ctrl_if #(.WIDTH(W)) bus1 ();
  shift_xfer_ctrl_if #(.WIDTH(W)) bus3 ();

  assign bus1.in_valid = in_valid;  assign bus3.in_valid = in_valid;
  assign bus1.din = din;            assign bus3.din = din;
  assign bus1.dout_ready = dout_ready; assign bus3.dout_ready = dout_ready;
  assign inr_o  = {bus3.in_ready, bus1.in_ready};
  assign dv_o   = {bus3.dout_valid, bus1.dout_valid};
  assign dout_o[0] = bus1.dout;     assign dout_o[1] = bus3.dout;
  assign bc_o[0] = bc1;             assign bc_o[1] = bc3;

  shift_xfer_ctrl #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .abort(abort), .SI(si[0]), .SO(so_o[0]),
    .shift_tick(tick_o[0]), .busy(busy_o[0]), .bit_cnt(bc1), .bus(bus1)
  );
  shift_xfer_ctrl #(.WIDTH(W), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .abort(abort), .SI(si[1]), .SO(so_o[1]),
    .shift_tick(tick_o[1]), .busy(busy_o[1]), .bit_cnt(bc3), .bus(bus3)
  );

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0=waiting for a word, 1=transferring, 2=result pending.
  int           ph [2] = '{0, 0};
  int           el [2] = '{0, 0};
  int           ns [2] = '{0, 0};
  logic [W-1:0] sr [2] = '{'0, '0};
  logic [W-1:0] dm [2] = '{'0, '0};

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic tick_exp(input int k);
    return (ph[k] == 1) && ((el[k] % div_of(k)) == div_of(k) - 1);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; el[k] = 0; ns[k] = 0; sr[k] = '0; dm[k] = '0;
      end else if (ph[k] == 0) begin
        if (in_valid) begin
          ph[k] = 1; el[k] = 0; ns[k] = 0; sr[k] = din;
        end
      end else if (abort) begin
        ph[k] = 0; ns[k] = 0;
      end else if (ph[k] == 1) begin
        if (tick_exp(k)) begin
          sr[k] = {sr[k][W-2:0], si[k]};
          ns[k] = ns[k] + 1;
          if (ns[k] == W) begin
            dm[k] = sr[k];
            ph[k] = 2;
          end
        end
        el[k] = el[k] + 1;
      end else if (dout_ready) begin
        ph[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("m%0d_in_ready", k), inr_o[k], ph[k] == 0);
      check_eq($sformatf("m%0d_busy", k), busy_o[k], ph[k] != 0);
      check_eq($sformatf("m%0d_dout_valid", k), dv_o[k], ph[k] == 2);
      check_eq($sformatf("m%0d_tick", k), tick_o[k], tick_exp(k));
      check_eq($sformatf("m%0d_so", k), so_o[k], sr[k][W-1]);
      check_eq($sformatf("m%0d_bit_cnt", k), bc_o[k], ns[k]);
      check_eq($sformatf("m%0d_dout", k), dout_o[k], dm[k]);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_in_ready"}, inr_o[k], 1);
      check_eq({tag, "_busy"}, busy_o[k], 0);
      check_eq({tag, "_dout_valid"}, dv_o[k], 0);
      check_eq({tag, "_dout"}, dout_o[k], 0);
      check_eq({tag, "_bit_cnt"}, bc_o[k], 0);
      check_eq({tag, "_so"}, so_o[k], 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; dout_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic accept(input logic [W-1:0] w);
    din = w; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] tx, pat;

    // Reset state
    do_reset();
    cycle();
    check_reset("rst");

    // DIV=1 transfer with a fixed SI pattern, then a stalled result handshake
    tx = 4'b1100; pat = 4'b1011;
    accept(tx);
    lat = 0;
    while (!dv_o[0] && lat < 20) begin
      if (lat < W) begin
        check_eq("t1_so_order", so_o[0], tx[W-1-lat]);
        si[0] = pat[W-1-lat];
      end
      cycle();
      lat++;
    end
    check_eq("t1_latency", lat, 4);
    check_eq("t1_dout", dout_o[0], 4'b1011);
    check_eq("t1_bit_cnt", bc_o[0], 4);
    in_valid = 1'b1; din = 4'b0110;
    repeat (5) begin
      cycle();
      check_eq("hold_dout", dout_o[0], 4'b1011);
      check_eq("hold_in_ready", inr_o[0], 0);
      check_eq("hold_valid", dv_o[0], 1);
    end
    in_valid = 1'b0; dout_ready = 1'b1;
    cycle();
    dout_ready = 1'b0;
    check_eq("release_in_ready", inr_o[0], 1);
    check_eq("release_valid", dv_o[0], 0);
    accept(4'b0110);
    check_eq("next_accept_busy", busy_o[0], 1);
    do_reset();

    // DIV=3 loopback
    accept(4'b1001);
    lat = 0;
    while (!dv_o[1] && lat < 50) begin
      si = so_o;
      cycle();
      lat++;
    end
    check_eq("t2_latency", lat, 12);
    check_eq("t2_dout", dout_o[1], 4'b1001);
    dout_ready = 1'b1;
    cycle();
    dout_ready = 1'b0;

    // Abort after two shifts, then a clean transfer
    accept(4'b0011);
    cycle(); cycle();
    check_eq("abort_pre_bit_cnt", bc_o[0], 2);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check_eq("abort_in_ready", inr_o[0], 1);
    check_eq("abort_bit_cnt", bc_o[0], 0);
    check_eq("abort_valid", dv_o[0], 0);
    check_eq("abort_dout_kept", dout_o[0], 4'b1001);
    accept(4'b0101);
    lat = 0;
    while (!dv_o[0] && lat < 20) begin
      si = so_o;
      cycle();
      lat++;
    end
    check_eq("after_abort_dout", dout_o[0], 4'b0101);
    do_reset();

    // Reset mid-transfer, alone and together with abort
    accept(4'b1110);
    cycle(); cycle();
    check_eq("midrst_pre_bit_cnt", bc_o[0], 2);
    do_reset();
    check_reset("midrst");
    accept(4'b1110);
    cycle(); cycle();
    rst = 1'b1; abort = 1'b1;
    cycle();
    rst = 1'b0; abort = 1'b0;
    check_reset("rst_abort");

    // in_valid with a different word during the transfer is ignored
    accept(4'b1110);
    si = so_o;
    din = 4'b0001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!dv_o[0] && lat < 20) begin
      si = so_o;
      cycle();
      lat++;
    end
    check_eq("ignore_iv_dout", dout_o[0], 4'b1110);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      abort      = ($urandom_range(0, 24) == 0);
      in_valid   = 1'($urandom);
      din        = W'($urandom);
      si         = 2'($urandom);
      dout_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
